alu_cmd_issuer: RTL and testbench

- Initiator side of the 3-bit-opcode 4-bit signed ALU interface.
- Accepts operation commands on a valid/ready port and buffers them in a small FIFO.
- Drives one command at a time onto the combinational ALU's A/B/opt inputs, samples its result and flags, and returns them on a valid/ready response port with a tag echo.
- Sits between the datapath controller and the combinational ALU.

---
 rtl/alu_cmd_issuer.sv | 188 ++++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Command issuer for a combinational 4-bit signed ALU: queues commands, drives
// one at a time onto the ALU and returns the captured result, flags and tag.
module alu_cmd_issuer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_opt,
    input  logic [3:0]       alu_result,
    input  logic             alu_less,
    input  logic             alu_equal,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [3:0]       resp_result,
    output logic [4:0]       resp_flags,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy,
    output logic [7:0]       op_count
);

    localparam int unsigned DATA_W = 4;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned FLAG_W = 5;
    localparam int unsigned CNT_W_ = 8;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    cmd_t               fifo_mem [DEPTH];
    cmd_t               head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occupancy;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               capture;
    logic               complete;
    logic [TAG_W-1:0]   tag_q;

    assign empty     = (occupancy == '0);
    assign full      = (occupancy == OCC_W'(DEPTH));
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = fifo_mem[rd_ptr];
    assign busy      = (state_q != IDLE) || !empty;

    // Command storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{tag: cmd_tag, op: cmd_op, a: cmd_a, b: cmd_b};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                state_d = RESP;
            end
            RESP: begin
                // Back-to-back issue: a queued command skips the IDLE bubble.
                if (resp_ready) begin
                    state_d = empty ? IDLE : DRIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        pop      = 1'b0;
        capture  = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                pop = !empty;
            end
            DRIVE: begin
                capture = 1'b1;
            end
            RESP: begin
                complete = resp_ready;
                pop      = resp_ready && !empty;
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

    // ALU operand registers and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_opt     <= '0;
            tag_q       <= '0;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_flags  <= '0;
            resp_tag    <= '0;
            op_count    <= '0;
        end else begin
            if (pop) begin
                alu_a   <= head.a;
                alu_b   <= head.b;
                alu_opt <= head.op;
                tag_q   <= head.tag;
            end
            if (capture) begin
                resp_result <= alu_result;
                resp_flags  <= FLAG_W'({alu_less, alu_equal, alu_carry, alu_overflow, alu_zero});
                resp_tag    <= tag_q;
                resp_valid  <= 1'b1;
            end
            if (complete) begin
                resp_valid <= 1'b0;
                op_count   <= op_count + CNT_W_'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural ALU and a response scoreboard.
module tb_alu_cmd_issuer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = '0;
    logic [3:0]       cmd_a = '0;
    logic [3:0]       cmd_b = '0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [2:0]       alu_opt;
    logic [3:0]       alu_result;
    logic             alu_less;
    logic             alu_equal;
    logic             alu_carry;
    logic             alu_overflow;
    logic             alu_zero;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [3:0]       resp_result;
    logic [4:0]       resp_flags;
    logic [TAG_W-1:0] resp_tag;
    logic             busy;
    logic [7:0]       op_count;

    typedef struct {
        logic [3:0]       result;
        logic [4:0]       flags;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   resp_seen = 0;

    alu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opt(alu_opt),
        .alu_result(alu_result), .alu_less(alu_less), .alu_equal(alu_equal),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_flags(resp_flags), .resp_tag(resp_tag), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {result[3:0], less, equal, carry, overflow, zero}.
    function automatic logic [8:0] alu_model(input logic [2:0] op, input logic [3:0] a,
                                             input logic [3:0] b);
        logic [4:0] s;
        logic [3:0] r;
        logic       c;
        logic       v;
        s = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[3:0];
                c = s[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            3'b001, 3'b110, 3'b111: begin
                s = {1'b0, a} + {1'b0, ~b} + 5'd1;
                r = s[3:0];
                c = s[4];
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            3'b010:  r = ~a;
            3'b011:  r = a & b;
            3'b100:  r = a | b;
            default: r = a ^ b;
        endcase
        return {r, ($signed(a) < $signed(b)), (a == b), c, v, (r == 4'd0)};
    endfunction

    always_comb begin
        {alu_result, alu_less, alu_equal, alu_carry, alu_overflow, alu_zero} =
            alu_model(alu_opt, alu_a, alu_b);
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Scoreboard pop on every response handshake (sampled mid-cycle).
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            exp_t e;
            resp_seen++;
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_result", 32'(resp_result), 32'(e.result));
                check("sb_flags", 32'(resp_flags), 32'(e.flags));
                check("sb_tag", 32'(resp_tag), 32'(e.tag));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [TAG_W-1:0] tag);
        int n;
        logic [8:0] m;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", 32'(cmd_ready), 32'd1);
        if (cmd_ready) begin
            m = alu_model(op, a, b);
            e.result = m[8:5];
            e.flags  = m[4:0];
            e.tag    = tag;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_one(input string name, input logic [2:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic [TAG_W-1:0] tag,
                           input logic [3:0] exp_res, input logic [4:0] exp_flags,
                           input logic [4:0] mask);
        int n;
        send(op, a, b, tag);
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, 32'(resp_valid), 32'd1);
        check({name, "_result"}, 32'(resp_result), 32'(exp_res));
        check({name, "_flags"}, 32'(resp_flags & mask), 32'(exp_flags));
        wait_idle(50);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        do_reset();
        @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_alu", 32'({alu_a, alu_b, alu_opt}), 32'd0);
        check("rst_resp", 32'({resp_result, resp_flags, resp_tag}), 32'd0);

        // ADD 7+1 with two-edge latency
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        send(3'b000, 4'b0111, 4'b0001, 4'd3);
        @(negedge clk);
        check("t1_lat_e0", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("t1_lat_e1", 32'(resp_valid), 32'd0);
        check("t1_alu_drive", 32'({alu_a, alu_b, alu_opt}), 32'({4'b0111, 4'b0001, 3'b000}));
        @(negedge clk);
        check("t1_lat_e2", 32'(resp_valid), 32'd1);
        check("t1_result", 32'(resp_result), 32'b1000);
        check("t1_flags", 32'(resp_flags), 32'b00010);
        check("t1_tag", 32'(resp_tag), 32'd3);
        @(negedge clk);
        check("t1_op_count", 32'(op_count), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Flag pass-through: {less, equal, carry, overflow, zero}
        run_one("t2_sub", 3'b001, 4'b0000, 4'b0000, 4'd1, 4'b0000, 5'b00101, 5'b00111);
        run_one("t2_less", 3'b110, 4'b1000, 4'b0001, 4'd2, 4'b0111, 5'b10110, 5'b10110);
        run_one("t3_eq1", 3'b111, 4'b0101, 4'b0101, 4'd4, 4'b0000, 5'b01000, 5'b01000);
        run_one("t3_eq0", 3'b111, 4'b0101, 4'b0100, 4'd5, 4'b0001, 5'b00000, 5'b01000);
        check("t3_op_count", 32'(op_count), 32'd5);

        // Backpressure: one in RESP, four queued, sixth refused
        do_reset();
        resp_ready = 1'b0;
        send(3'b000, 4'd3, 4'd4, 4'd0);
        send(3'b001, 4'd2, 4'd6, 4'd1);
        send(3'b011, 4'hc, 4'ha, 4'd2);
        send(3'b100, 4'h9, 4'h6, 4'd3);
        send(3'b101, 4'hf, 4'h3, 4'd4);
        @(negedge clk);
        check("t4_full", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_tag   = 4'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_refuse", 32'(cmd_ready), 32'd0);
            check("t4_hold", 32'({resp_valid, resp_tag}), 32'({1'b1, 4'd0}));
        end
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_rate", 32'(resp_valid), 32'((i % 2) == 0));
        end
        wait_idle(50);
        check("t4_op_count", 32'(op_count), 32'd5);
        check("t4_sb_empty", 32'(sb.size()), 32'd0);

        // Reset while DRIVE holds a command and two more are queued
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        send(3'b000, 4'd1, 4'd1, 4'd6);
        send(3'b000, 4'd5, 4'd2, 4'd7);
        send(3'b011, 4'd6, 4'd3, 4'd8);
        send(3'b100, 4'd7, 4'd4, 4'd9);
        resp_ready = 1'b1;
        @(negedge clk);
        check("t5_first_resp", 32'(resp_valid), 32'd1);
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("t5_in_drive", 32'({alu_a, alu_b, resp_valid}), 32'({4'd5, 4'd2, 1'b0}));
        @(posedge clk);
        #1;
        rst = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        check("t5_resp_valid", 32'(resp_valid), 32'd0);
        check("t5_cmd_ready", 32'(cmd_ready), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_op_count", 32'(op_count), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t5_no_stale", 32'({resp_valid, busy}), 32'd0);
        end

        // 256 completions wrap op_count
        @(posedge clk);
        #1;
        begin
            int seen0;
            seen0 = resp_seen;
            for (int i = 0; i < 256; i++) begin
                send(3'($urandom_range(7)), 4'($urandom_range(15)), 4'($urandom_range(15)),
                     TAG_W'(i));
            end
            wait_idle(100);
            check("t6_count", 32'(resp_seen - seen0), 32'd256);
            check("t6_wrap", 32'(op_count), 32'd0);
            check("t6_sb_empty", 32'(sb.size()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
